stopwatch_ctrl: RTL

//  Control sequencer for the stopwatch seconds/minutes counter. Takes one-cycle button pulses and mode

---
 rtl/stopwatch_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: RUN/PAUSE/ADJUST FSM plus the count-tick,
// adjust-rate and blink prescalers. Every output to the counter is a
// registered single-cycle strobe.
// Optional feature: define STOPWATCH_LAP_EN to add the display_hold lap freeze.
module stopwatch_ctrl #(
  parameter int unsigned DIV_TICK  = 100_000_000,
  parameter int unsigned DIV_ADJ   = 50_000_000,
  parameter int unsigned DIV_BLINK = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adjust_sw,
  input  logic       sel_sw,
  output logic       count_en,
  output logic       cnt_clear,
  output logic       adj_inc,
  output logic       adj_sel,
  output logic       blink,
  output logic [1:0] state
`ifdef STOPWATCH_LAP_EN
  ,
  output logic       display_hold
`endif
);

  localparam int TICK_W  = $clog2(DIV_TICK);
  localparam int ADJ_W   = $clog2(DIV_ADJ);
  localparam int BLINK_W = $clog2(DIV_BLINK);

  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(DIV_TICK - 1);
  localparam logic [ADJ_W-1:0]   ADJ_MAX   = ADJ_W'(DIV_ADJ - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(DIV_BLINK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSE  = 2'b10,
    S_ADJUST = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ADJ_W-1:0]    adj_q, adj_d;
  logic [BLINK_W-1:0]  bl_q, bl_d;
  logic                count_en_q, count_en_d;
  logic                cnt_clear_q, cnt_clear_d;
  logic                adj_inc_q, adj_inc_d;
  logic                adj_sel_q, adj_sel_d;
  logic                blink_q, blink_d;
`ifdef STOPWATCH_LAP_EN
  logic                hold_q, hold_d;
  logic                lap_toggle;
`endif

  // Next-state, prescaler and strobe logic for the whole sequencer.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    state_d     = state_q;
    tick_d      = tick_q;
    adj_d       = '0;
    bl_d        = '0;
    count_en_d  = 1'b0;
    cnt_clear_d = 1'b0;
    adj_inc_d   = 1'b0;
    blink_d     = 1'b0;
    adj_sel_d   = sel_sw;
`ifdef STOPWATCH_LAP_EN
    lap_toggle  = 1'b0;
`endif

    // Mode transitions, highest priority first: clear, adjust, pause.
    if (clear_pulse) begin
      cnt_clear_d = 1'b1;
      if (state_q == S_RUN || state_q == S_PAUSE) begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (adjust_sw) begin
            state_d = S_ADJUST;
          end else if (pause_pulse) begin
            state_d = S_RUN;
            tick_d  = '0;
          end
        end
        S_RUN: begin
`ifdef STOPWATCH_LAP_EN
          if (adjust_sw && pause_pulse) begin
            lap_toggle = 1'b1;
          end else if (pause_pulse) begin
            state_d = S_PAUSE;
          end
`else
          if (pause_pulse) begin
            state_d = S_PAUSE;
          end
`endif
        end
        S_PAUSE: begin
          if (adjust_sw) begin
            state_d = S_ADJUST;
          end else if (pause_pulse) begin
            state_d = S_RUN;
          end
        end
        S_ADJUST: begin
          if (!adjust_sw) begin
            state_d = S_PAUSE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The tick prescaler only advances on cycles that stay in RUN, so a
    // pause in the terminal cycle holds the pending tick instead of losing it.
    if (state_q == S_RUN && state_d == S_RUN) begin
      if (tick_q == TICK_MAX) begin
        tick_d     = '0;
        count_en_d = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end

    // Adjust-rate and blink prescalers live only while ADJUST persists.
    if (state_d == S_ADJUST) begin
      if (state_q != S_ADJUST) begin
        adj_d   = '0;
        bl_d    = '0;
        blink_d = 1'b1;
      end else begin
        if (sel_sw != adj_sel_q) begin
          adj_d = '0;
        end else if (adj_q == ADJ_MAX) begin
          adj_d     = '0;
          adj_inc_d = 1'b1;
        end else begin
          adj_d = adj_q + 1'b1;
        end
        if (bl_q == BLINK_MAX) begin
          bl_d    = '0;
          blink_d = ~blink_q;
        end else begin
          bl_d    = bl_q + 1'b1;
          blink_d = blink_q;
        end
      end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap freeze survives only while RUN persists; any exit or clear drops it.
    if (state_q == S_RUN && state_d == S_RUN) begin
      hold_d = hold_q ^ lap_toggle;
    end else begin
      hold_d = 1'b0;
    end
`endif
  end

  // State, prescaler and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      adj_q       <= '0;
      bl_q        <= '0;
      count_en_q  <= 1'b0;
      cnt_clear_q <= 1'b0;
      adj_inc_q   <= 1'b0;
      adj_sel_q   <= 1'b0;
      blink_q     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      adj_q       <= adj_d;
      bl_q        <= bl_d;
      count_en_q  <= count_en_d;
      cnt_clear_q <= cnt_clear_d;
      adj_inc_q   <= adj_inc_d;
      adj_sel_q   <= adj_sel_d;
      blink_q     <= blink_d;
`ifdef STOPWATCH_LAP_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign count_en  = count_en_q;
  assign cnt_clear = cnt_clear_q;
  assign adj_inc   = adj_inc_q;
  assign adj_sel   = adj_sel_q;
  assign blink     = blink_q;
  assign state     = state_q;
`ifdef STOPWATCH_LAP_EN
  assign display_hold = hold_q;
`endif

endmodule
